// File: rtl/if_id_pipe_reg_if.sv
// Fetch/decode handshake bundle for the IF/ID skid-buffer stage.
// The stage connects through the slave modport; fetch/decode drive the master side.
interface if_id_pipe_reg_if #(
    parameter int XLEN = 32,
    parameter int SB_W = 1
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] ir_i;
    logic [SB_W-1:0] sb_i;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] ir_o;
    logic [SB_W-1:0] sb_o;

    modport master (
        output in_valid, pc_i, ir_i, sb_i, out_ready,
        input  in_ready, out_valid, pc_o, ir_o, sb_o
    );

    modport slave (
        input  in_valid, pc_i, ir_i, sb_i, out_ready,
        output in_ready, out_valid, pc_o, ir_o, sb_o
    );
endinterface

// File: rtl/if_id_pipe_reg.sv
// Elastic IF/ID stage: 2-entry skid buffer with flush and pre-sliced RV32I fields.
// Optional stall/bubble counters are built only when IF_ID_PERF_EN is defined.
//
// state | meaning
// EMPTY | nothing held; head shows pc=0 / NOP / sb=0
// ONE   | head valid, skid unused
// FULL  | head and skid valid (skid is younger); in_ready low
module if_id_pipe_reg #(
    parameter int              XLEN      = 32,
    parameter int              SB_W      = 1,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    if_id_pipe_reg_if.slave      bus,
    output logic [6:0]           opcode,
    output logic [2:0]           funct3,
    output logic [6:0]           funct7,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [31:0]          perf_stall,
    output logic [31:0]          perf_bubble
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] head_pc, head_ir, skid_pc, skid_ir;
    logic [SB_W-1:0] head_sb, skid_sb;
    logic            accept, pop;

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = out_valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_pc     <= '0;
            head_ir     <= NOP_INSTR;
            head_sb     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_pc     <= bus.pc_i;
                        head_ir     <= bus.ir_i;
                        head_sb     <= bus.sb_i;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_pc <= bus.pc_i;
                        head_ir <= bus.ir_i;
                        head_sb <= bus.sb_i;
                    end else if (accept) begin
                        skid_pc    <= bus.pc_i;
                        skid_ir    <= bus.ir_i;
                        skid_sb    <= bus.sb_i;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        // reload the bubble payload so decode never sees a stale instruction
                        head_pc     <= '0;
                        head_ir     <= NOP_INSTR;
                        head_sb     <= '0;
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_pc    <= skid_pc;
                        head_ir    <= skid_ir;
                        head_sb    <= skid_sb;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    head_pc     <= '0;
                    head_ir     <= NOP_INSTR;
                    head_sb     <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pc_o      = head_pc;
    assign bus.ir_o      = head_ir;
    assign bus.sb_o      = head_sb;

    assign opcode = head_ir[6:0];
    assign rd     = head_ir[11:7];
    assign funct3 = head_ir[14:12];
    assign rs1    = head_ir[19:15];
    assign rs2    = head_ir[24:20];
    assign funct7 = head_ir[31:25];

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid_q && !bus.out_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid_q && bubble_cnt != 32'hFFFF_FFFF)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign perf_stall  = stall_cnt;
    assign perf_bubble = bubble_cnt;
`else
    assign perf_stall  = '0;
    assign perf_bubble = '0;
`endif

endmodule
